// File: rtl/mips_cpu_load_extend.sv
// Load-data alignment/extension unit: one memory read per request, lane select, sign/zero extend.
// Optional LWL/LWR merge support is compiled in when MIPS_CPU_LOAD_LWLR_EN is defined.
module mips_cpu_load_extend #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_WAIT   = 255,
    localparam int OFFSET_W   = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_mode,
    input  logic [OFFSET_W-1:0]   req_offset,
    input  logic [31:0]           req_rt,
    output logic                  mem_read,
    input  logic                  mem_waitrequest,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic                  res_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [2:0] {
        M_LB  = 3'b000,
        M_LBU = 3'b001,
        M_LH  = 3'b010,
        M_LHU = 3'b011,
        M_LW  = 3'b100,
        M_LWL = 3'b101,
        M_LWR = 3'b110,
        M_RSV = 3'b111
    } mode_e;

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;
    logic                req_illegal;
    logic [OFFSET_W-1:0] word_off;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [31:0]         word_lane;
    logic [31:0]         load_data;

`ifdef MIPS_CPU_LOAD_LWLR_EN
    logic [31:0]         rt_q, rt_d;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        req_illegal = 1'b0;
        case (mode_e'(req_mode))
            M_LH, M_LHU: req_illegal = req_offset[0];
            M_LW:        req_illegal = (req_offset[1:0] != 2'b00);
`ifdef MIPS_CPU_LOAD_LWLR_EN
            M_LWL, M_LWR: req_illegal = 1'b0;
`else
            M_LWL, M_LWR: req_illegal = 1'b1;
`endif
            M_RSV:       req_illegal = 1'b1;
            default:     req_illegal = 1'b0;
        endcase
    end

    // Byte/half lanes start at the byte offset; the word lane uses the 32-bit aligned slot.
    assign word_off  = off_q & ~OFFSET_W'(3);
    assign byte_lane = mem_readdata[{off_q, 3'b000} +: 8];
    assign half_lane = mem_readdata[{off_q, 3'b000} +: 16];
    assign word_lane = mem_readdata[{word_off, 3'b000} +: 32];

    always_comb begin
        load_data = 32'h0;
        case (mode_q)
            M_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
            M_LBU: load_data = {24'h0, byte_lane};
            M_LH:  load_data = {{16{half_lane[15]}}, half_lane};
            M_LHU: load_data = {16'h0, half_lane};
            M_LW:  load_data = word_lane;
`ifdef MIPS_CPU_LOAD_LWLR_EN
            M_LWL: begin
                case (off_q[1:0])
                    2'd0:    load_data = {word_lane[7:0],  rt_q[23:0]};
                    2'd1:    load_data = {word_lane[15:0], rt_q[15:0]};
                    2'd2:    load_data = {word_lane[23:0], rt_q[7:0]};
                    default: load_data = word_lane;
                endcase
            end
            M_LWR: begin
                case (off_q[1:0])
                    2'd0:    load_data = word_lane;
                    2'd1:    load_data = {rt_q[31:24], word_lane[31:8]};
                    2'd2:    load_data = {rt_q[31:16], word_lane[31:16]};
                    default: load_data = {rt_q[31:8],  word_lane[31:24]};
                endcase
            end
`endif
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef MIPS_CPU_LOAD_LWLR_EN
        rt_d    = rt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_illegal) begin
                        state_d = S_RESP;
                        data_d  = 32'h0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        mode_d  = mode_e'(req_mode);
                        off_d   = req_offset;
                        cnt_d   = 8'd0;
`ifdef MIPS_CPU_LOAD_LWLR_EN
                        rt_d    = req_rt;
`endif
                    end
                end
            end
            S_WAIT: begin
                if (!mem_waitrequest) begin
                    state_d = S_RESP;
                    data_d  = load_data;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == 8'(MAX_WAIT)) begin
                        state_d = S_RESP;
                        data_d  = 32'h0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_LB;
            off_q   <= '0;
            cnt_q   <= 8'd0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
`ifdef MIPS_CPU_LOAD_LWLR_EN
            rt_q    <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef MIPS_CPU_LOAD_LWLR_EN
            rt_q    <= rt_d;
`endif
        end
    end

    // req_rt is only consumed by the merge logic.
`ifndef MIPS_CPU_LOAD_LWLR_EN
    logic unused_rt;
    assign unused_rt = ^req_rt;
`endif

    assign req_ready = (state_q == S_IDLE);
    assign mem_read  = (state_q == S_WAIT);
    assign res_valid = (state_q == S_RESP);
    assign res_data  = data_q;
    assign res_error = err_q;

endmodule
